// File: rtl/cla_sub_pipe32.sv
// Two-stage pipelined 32-bit subtractor (a - b - bi) built from 16-bit CLA
// slices, with borrow-out, signed-overflow and zero flags.
// Ports: clk, rst (async, active-high); in_valid/in_ready with a, b, bi;
//        out_valid/out_ready with diff, bo, ovf, zero.
module cla_sub_pipe32 #(
  parameter int WIDTH = 32,
  parameter int SLICE = WIDTH / 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bo,
  output logic             ovf,
  output logic             zero
);

  // 16-bit carry-lookahead add: 4-bit groups with group generate/propagate.
  // Returns {carry_out, sum}.
  function automatic logic [16:0] cla16(
    input logic [15:0] x,
    input logic [15:0] y,
    input logic        ci
  );
    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:0]  gc;
    g = x & y;
    p = x ^ y;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    gc[0] = ci;
    gc[1] = gg[0] | (gp[0] & ci);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & ci);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & ci);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
          | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & ci);
    for (int k = 0; k < 4; k++) begin
      c[4*k] = gc[k];
      for (int i = 1; i < 4; i++) begin
        c[4*k+i] = g[4*k+i-1] | (p[4*k+i-1] & c[4*k+i-1]);
      end
    end
    return {gc[4], p ^ c};
  endfunction

  // Stage-1 registers
  logic             s1_valid_q, s1_valid_d;
  logic [SLICE-1:0] s1_dlo_q, s1_dlo_d;
  logic             s1_c16_q, s1_c16_d;
  logic [SLICE-1:0] s1_ahi_q, s1_ahi_d;
  logic [SLICE-1:0] s1_bhi_q, s1_bhi_d;

  // Output registers
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bo_q, bo_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic             accept;
  logic             s2_adv;
  logic [SLICE:0]   lo_sum;
  logic [SLICE:0]   hi_sum;
  logic [WIDTH-1:0] res;

  assign in_ready = !s1_valid_q || !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign s2_adv   = s1_valid_q && (!out_valid_q || out_ready);

  // Subtract as a + ~b + ~bi; the high slice only sees registered values.
  assign lo_sum = cla16(a[SLICE-1:0], ~b[SLICE-1:0], ~bi);
  assign hi_sum = cla16(s1_ahi_q, ~s1_bhi_q, s1_c16_q);
  assign res    = {hi_sum[SLICE-1:0], s1_dlo_q};

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_dlo_d   = s1_dlo_q;
    s1_c16_d   = s1_c16_q;
    s1_ahi_d   = s1_ahi_q;
    s1_bhi_d   = s1_bhi_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_dlo_d   = lo_sum[SLICE-1:0];
      s1_c16_d   = lo_sum[SLICE];
      s1_ahi_d   = a[WIDTH-1:SLICE];
      s1_bhi_d   = b[WIDTH-1:SLICE];
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    diff_d      = diff_q;
    bo_d        = bo_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    if (s2_adv) begin
      out_valid_d = 1'b1;
      diff_d      = res;
      bo_d        = ~hi_sum[SLICE];
      ovf_d       = (s1_ahi_q[SLICE-1] ^ s1_bhi_q[SLICE-1])
                  & (s1_ahi_q[SLICE-1] ^ hi_sum[SLICE-1]);
      zero_d      = ~|res;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_dlo_q   <= '0;
      s1_c16_q   <= 1'b0;
      s1_ahi_q   <= '0;
      s1_bhi_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_dlo_q   <= s1_dlo_d;
      s1_c16_q   <= s1_c16_d;
      s1_ahi_q   <= s1_ahi_d;
      s1_bhi_q   <= s1_bhi_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      bo_q        <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      diff_q      <= diff_d;
      bo_q        <= bo_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bo        = bo_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_cla_sub_pipe32.sv
// Self-checking bench for cla_sub_pipe32: directed vectors, handshake
// scenarios and randomized traffic against an arithmetic reference model.
module tb_cla_sub_pipe32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        bi = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] diff;
  logic        bo;
  logic        ovf;
  logic        zero;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cla_sub_pipe32 dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bi(bi),
    .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bo(bo), .ovf(ovf), .zero(zero)
  );

  // Reference: {bo, ovf, zero, diff} from plain 33-bit arithmetic.
  function automatic logic [34:0] model(
    input logic [31:0] x,
    input logic [31:0] y,
    input logic        c
  );
    logic [32:0] full;
    logic [31:0] d;
    full = {1'b0, x} - {1'b0, y} - 33'(c);
    d = full[31:0];
    return {full[32], (x[31] ^ y[31]) & (x[31] ^ d[31]), d == 32'd0, d};
  endfunction

  function automatic logic [31:0] rnd32();
    logic [31:0] sp[6];
    sp = '{32'h0, 32'hFFFFFFFF, 32'h80000000,
           32'h7FFFFFFF, 32'h0000FFFF, 32'h00010000};
    if ($urandom_range(3, 0) == 0) return sp[$urandom_range(5, 0)];
    return $urandom;
  endfunction

  task automatic test_reset();
    #2;
    checks++;
    if ({out_valid, diff, bo, ovf, zero, in_ready} !== {1'b0, 32'd0, 4'b0001}) begin
      errs++;
      $display("FAIL reset: got v=%b d=%h bo=%b ovf=%b z=%b rdy=%b want v=0 d=0 flags=0 rdy=1",
               out_valid, diff, bo, ovf, zero, in_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] ta[4];
    logic [31:0] tb_[4];
    logic        tc[4];
    logic [34:0] te[4];
    ta  = '{32'd5, 32'd0, 32'h80000000, 32'h7FFFFFFF};
    tb_ = '{32'd3, 32'd0, 32'd1, 32'hFFFFFFFF};
    tc  = '{1'b0, 1'b1, 1'b0, 1'b0};
    te  = '{{3'b000, 32'h00000002}, {3'b100, 32'hFFFFFFFF},
            {3'b010, 32'h7FFFFFFF}, {3'b110, 32'h80000000}};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = ta[i]; b = tb_[i]; bi = tc[i];
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errs++;
        $display("FAIL dir%0d_ready: got %b want 1", i, in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
        errs++;
        $display("FAIL dir%0d_early: out_valid got %b want 0", i, out_valid);
      end
      @(negedge clk);
      checks++;
      if ({out_valid, bo, ovf, zero, diff} !== {1'b1, te[i]}) begin
        errs++;
        $display("FAIL dir%0d: got v=%b bo=%b ovf=%b z=%b d=%h want v=1 %h",
                 i, out_valid, bo, ovf, zero, diff, te[i]);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errs++;
        $display("FAIL dir%0d_dup: out_valid got %b want 0", i, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; a = 32'h00010000; b = 32'd1; bi = 1'b0;
    @(negedge clk);
    a = 32'h12345678; b = 32'h12345678;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({out_valid, bo, ovf, zero, diff} !== {4'b1000, 32'h0000FFFF}) begin
      errs++;
      $display("FAIL b2b_first: got v=%b bo=%b ovf=%b z=%b d=%h want v=1 d=0000ffff flags=000",
               out_valid, bo, ovf, zero, diff);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, bo, ovf, zero, diff} !== {4'b1001, 32'h0}) begin
      errs++;
      $display("FAIL b2b_second: got v=%b bo=%b ovf=%b z=%b d=%h want v=1 d=0 z=1",
               out_valid, bo, ovf, zero, diff);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errs++;
      $display("FAIL b2b_tail: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    bi = 1'b0; b = 32'd1;
    @(negedge clk);
    in_valid = 1'b1; a = 32'd10;
    @(negedge clk);
    a = 32'd20;
    @(negedge clk);
    a = 32'd30;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({in_ready, out_valid, diff} !== {2'b01, 32'd9}) begin
        errs++;
        $display("FAIL bp_stall%0d: got rdy=%b v=%b d=%0d want rdy=0 v=1 d=9",
                 i, in_ready, out_valid, diff);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, diff} !== {2'b11, 32'd9}) begin
      errs++;
      $display("FAIL bp_release: got rdy=%b v=%b d=%0d want rdy=1 v=1 d=9",
               in_ready, out_valid, diff);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({out_valid, diff} !== {1'b1, 32'd19}) begin
      errs++;
      $display("FAIL bp_second: got v=%b d=%0d want v=1 d=19", out_valid, diff);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, diff} !== {1'b1, 32'd29}) begin
      errs++;
      $display("FAIL bp_third: got v=%b d=%0d want v=1 d=29", out_valid, diff);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errs++;
      $display("FAIL bp_empty: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_random();
    logic [34:0] q[$];
    logic [34:0] exp;
    int          n;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(3, 0) != 0);
      a         = rnd32();
      b         = rnd32();
      bi        = 1'($urandom_range(1, 0));
      out_ready = ($urandom_range(3, 0) != 0);
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errs++;
          $display("FAIL rnd_spurious: cycle %0d d=%h with nothing expected", cyc, diff);
        end else begin
          exp = q.pop_front();
          if ({bo, ovf, zero, diff} !== exp) begin
            errs++;
            $display("FAIL rnd_beat: cycle %0d got bo=%b ovf=%b z=%b d=%h want %h",
                     cyc, bo, ovf, zero, diff, exp);
          end
        end
      end
      if (in_valid && in_ready) q.push_back(model(a, b, bi));
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 10) begin
      #1;
      if (out_valid) begin
        exp = q.pop_front();
        checks++;
        if ({bo, ovf, zero, diff} !== exp) begin
          errs++;
          $display("FAIL rnd_drain: got bo=%b ovf=%b z=%b d=%h want %h",
                   bo, ovf, zero, diff, exp);
        end
      end
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0 || out_valid !== 1'b0) begin
      errs++;
      $display("FAIL rnd_lost: left=%0d out_valid=%b want left=0 out_valid=0",
               q.size(), out_valid);
    end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    bi = 1'b0; b = 32'd2;
    @(negedge clk);
    in_valid = 1'b1; a = 32'd100;
    @(negedge clk);
    a = 32'd200;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, diff, in_ready} !== {1'b0, 32'd0, 1'b1}) begin
      errs++;
      $display("FAIL rst_mid: got v=%b d=%h rdy=%b want v=0 d=0 rdy=1",
               out_valid, diff, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errs++;
        $display("FAIL rst_stale%0d: out_valid got %b want 0 d=%h", i, out_valid, diff);
      end
    end
    in_valid = 1'b1; a = 32'd7;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, bo, ovf, zero, diff} !== {4'b1000, 32'd5}) begin
      errs++;
      $display("FAIL rst_after: got v=%b bo=%b ovf=%b z=%b d=%0d want v=1 d=5 flags=000",
               out_valid, bo, ovf, zero, diff);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
